// File: rtl/jam_pkg.sv
// Shared types and constants for the JAM cost server: state encoding, table geometry
// and the value the captured minimum cost holds until the engine reports.
package jam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_W      = 8;
    localparam int N_J      = 8;
    localparam int N_ENTRY  = N_W * N_J;
    localparam int IDX_W    = 6;
    localparam int COST_W   = 7;
    localparam int RESULT_W = 10;
    localparam int COUNT_W  = 4;
    localparam int REQ_W    = 16;

    localparam logic [RESULT_W-1:0] MINCOST_INIT = 10'd1023;

    function automatic logic [REQ_W-1:0] sat_inc(input logic [REQ_W-1:0] v);
        return (v == {REQ_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/jam_cost_table.sv
// 64-entry cost register file: one synchronous write port for the serial loader and
// one asynchronous read port so the engine sees its cost in the request cycle.
module jam_cost_table #(
    parameter int COST_W = jam_pkg::COST_W
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [5:0]        waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [5:0]        raddr,
    output logic [COST_W-1:0] rdata
);
    import jam_pkg::*;

    // Contents are deliberately not reset; the engine is held off until a full load.
    logic [COST_W-1:0] mem [N_ENTRY];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_server.sv
// Responder side of the JAM worker/job cost interface: loads the table, serves costs,
// captures the result. Define JAM_COST_CHKSUM_EN to add the 13-bit load checksum port.
//
// state | meaning
// IDLE  | after reset, engine held in reset, waiting for load_start
// LOAD  | accepting 64 table beats, engine held in reset
// SERVE | engine running, Cost answered combinationally, timeout counting
// DONE  | result captured (or timed out), engine held in reset
module jam_cost_server #(
    parameter int TIMEOUT = 65535,
    parameter int COST_W  = jam_pkg::COST_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [COST_W-1:0] load_data,
    output logic              load_ready,
    output logic              jam_rst,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [9:0]        MinCost,
    input  logic [3:0]        MatchCount,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [9:0]        result_min,
    output logic [3:0]        result_cnt,
    output logic [15:0]       req_cnt
`ifdef JAM_COST_CHKSUM_EN
    ,
    output logic [12:0]       chksum
`endif
);
    import jam_pkg::*;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [15:0]          tcnt_q;
    logic [5:0]           wj_prev_q;
    logic                 in_serve_q;
    logic                 jam_rst_q;
    logic                 timeout_q;
    logic [RESULT_W-1:0]  result_min_q;
    logic [COUNT_W-1:0]   result_cnt_q;
    logic [REQ_W-1:0]     req_cnt_q;
    logic [COST_W-1:0]    rdata;
    logic                 beat;
    logic                 tmo_hit;
    logic                 wj_new;

    // A load_start beat is discarded: the restart takes the cycle instead.
    assign beat    = (state_q == LOAD) && load_valid && !load_start;
    assign tmo_hit = (tcnt_q == TMO_LAST);
    assign wj_new  = !in_serve_q || ({W, J} != wj_prev_q);

    jam_cost_table #(.COST_W(COST_W)) u_table (
        .CLK   (CLK),
        .we    (beat),
        .waddr (idx_q),
        .wdata (load_data),
        .raddr ({W, J}),
        .rdata (rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        Cost       = '0;
        case (state_q)
            IDLE: begin
                if (load_start) state_d = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
                if (!load_start && beat && (idx_q == 6'd63)) state_d = SERVE;
            end
            SERVE: begin
                busy = 1'b1;
                Cost = rdata;
                if (load_start)   state_d = LOAD;
                else if (Valid)   state_d = DONE;
                else if (tmo_hit) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (load_start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q        <= '0;
            tcnt_q       <= '0;
            wj_prev_q    <= '0;
            in_serve_q   <= 1'b0;
            jam_rst_q    <= 1'b1;
            timeout_q    <= 1'b0;
            result_min_q <= MINCOST_INIT;
            result_cnt_q <= '0;
            req_cnt_q    <= '0;
        end else begin
            // Registered from the next state so the engine leaves reset with the table complete.
            jam_rst_q  <= (state_d != SERVE);
            in_serve_q <= (state_q == SERVE);
            wj_prev_q  <= {W, J};
            if (load_start) begin
                idx_q        <= '0;
                tcnt_q       <= '0;
                timeout_q    <= 1'b0;
                result_min_q <= MINCOST_INIT;
                result_cnt_q <= '0;
                req_cnt_q    <= '0;
            end else begin
                if (beat) begin
                    idx_q <= idx_q + 1'b1;
                end
                if (state_q == SERVE) begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (wj_new) begin
                        req_cnt_q <= sat_inc(req_cnt_q);
                    end
                    if (Valid) begin
                        result_min_q <= MinCost;
                        result_cnt_q <= MatchCount;
                        timeout_q    <= 1'b0;
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef JAM_COST_CHKSUM_EN
    always_ff @(posedge CLK) begin
        if (RST || load_start) begin
            chksum <= '0;
        end else if (beat) begin
            chksum <= chksum + 13'(load_data);
        end
    end
`endif

    assign jam_rst    = jam_rst_q;
    assign timeout    = timeout_q;
    assign result_min = result_min_q;
    assign result_cnt = result_cnt_q;
    assign req_cnt    = req_cnt_q;

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Responder end of the JAM worker/job cost interface.
- Holds the 8x8 cost table, which is loaded serially by the host bench or upper level.
- Holds the JAM search engine in reset until the table is complete, then answers every (W,J) request with Cost in the same cycle.
- Captures MinCost/MatchCount when the engine raises Valid, or times out.

Parameters:
TIMEOUT, 65535, max SERVE cycles to wait for Valid before declaring timeout (16-bit counter)
COST_W, 7, cost entry width; must match the engine's Cost input

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high, sampled on rising CLK
load_start  in  1  pulse; begins (or restarts) a table load
load_valid  in  1  load_data valid this cycle
load_data  in  COST_W  next table entry, row-major: index = {W,J}, entry 0 first
load_ready  out  1  high in LOAD; transfer when load_valid & load_ready
jam_rst  out  1  reset to the search engine; high unless in SERVE
W  in  3  worker index from engine
J  in  3  job index from engine
Cost  out  COST_W  table[{W,J}] combinationally in SERVE; 0 otherwise
Valid  in  1  engine result strobe
MinCost  in  10  engine result
MatchCount  in  4  engine result
busy  out  1  state is LOAD or SERVE
done  out  1  high in DONE
timeout  out  1  DONE was reached by timeout; valid while done
result_min  out  10  captured MinCost
result_cnt  out  4  captured MatchCount
req_cnt  out  16  number of distinct (W,J) requests served (count of {W,J} changes in SERVE, saturating)

Behaviour:
- Reset values: state IDLE, load_ready=0, jam_rst=1, Cost=0, busy=0, done=0, timeout=0, result_min=1023, result_cnt=0, req_cnt=0, load index=0, timeout counter=0. Table contents are not reset.
- States: IDLE, LOAD, SERVE, DONE.
- IDLE:
  - load_start -> LOAD.
  - Load index, req_cnt, timeout counter and result_* are cleared on that edge.
  - done and timeout clear.
- LOAD:
  - Each accepted beat writes table[idx] and increments the 6-bit idx.
  - The beat with idx==63 moves the state to SERVE on the same edge; idx wraps to 0.
  - A load_start during LOAD restarts at idx 0; the current beat, if any, is discarded.
- jam_rst is registered: it falls on the first SERVE cycle and rises on the first cycle after leaving SERVE.
- The engine therefore sees at least one full table before its reset releases.
- SERVE:
  - Cost = table[{W,J}] with zero latency (asynchronous read); the engine samples it the cycle after it registers W/J.
  - req_cnt increments when {W,J} differs from the previous-cycle {W,J}; the first SERVE cycle always counts; saturates at 65535.
  - Timeout counter increments every cycle.
  - Valid=1 -> DONE; result_min<=MinCost, result_cnt<=MatchCount, timeout<=0.
  - Counter reaching TIMEOUT-1 without Valid -> DONE with timeout<=1; result_* stay cleared (1023/0).
  - Valid and timeout in the same cycle: Valid wins, timeout=0.
  - load_start in SERVE aborts -> LOAD, idx=0; priority over Valid.
- DONE:
  - Cost=0; outputs hold.
  - load_start -> LOAD: clears done and result_*, reloads the table.
  - The engine stays in reset, so it cannot double-report.
- Valid outside SERVE is ignored.
- RST mid-operation returns every output to its reset value on the next edge, regardless of state.

Optional Feature:
- JAM_COST_CHKSUM_EN defined:
  - Adds output port chksum (13 bits), the unsigned sum of all 64 accepted load_data beats of the current load.
  - Cleared on RST and on each load_start.
  - Stable from the first SERVE cycle.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Package jam_pkg holds:
  - state encoding: IDLE=0, LOAD=1, SERVE=2, DONE=3
  - N_W=8, N_J=8, COST_W=7, RESULT_W=10, COUNT_W=4
  - MINCOST_INIT=1023
- Sub-module jam_cost_table:
  - 64 x COST_W register file
  - one synchronous write port (we, waddr[5:0], wdata)
  - one asynchronous read port (raddr[5:0], rdata)
- The FSM, counters and capture logic stay in jam_cost_server.

Test Plan:
- Reset: hold RST 2 cycles -> jam_rst=1, busy=0, done=0, result_min=1023, result_cnt=0, Cost=0.
- Load/serve: load table[i]=i mod 100 with back-to-back beats, drive W=3,J=5 -> jam_rst falls on the cycle after the 64th beat; Cost=29 same cycle; busy=1.
- Full run: connect the JAM engine with a table whose minimum assignment cost is 0x0A3 with 2 matches -> done=1, result_min=163, result_cnt=2, timeout=0, req_cnt>=8.
- Gapped load with restart: load_valid toggles every other cycle; issue load_start after 20 beats -> idx restarts; SERVE is entered only after 64 further beats.
- Timeout: TIMEOUT=100, W/J stuck, Valid never asserted -> done and timeout both rise 100 cycles after SERVE entry; result_min=1023.
- Collision: load_start and Valid in the same SERVE cycle -> state LOAD, done=0, result_* unchanged from clear (1023/0), jam_rst=1 the next cycle.
